// File: rtl/core_dispatcher_if.sv
// Signal bundle between core_dispatcher, the job host, the four cores and the result consumer.
// Valid/ready: a transfer completes on a rising clk edge where valid and ready are both 1; the
// offering side holds its payload until then, and ready may depend combinationally on state only.
interface core_dispatcher_if #(
   parameter int DATA_W = 24
);
   logic              job_valid;
   logic [DATA_W-1:0] job_data;
   logic              job_ready;

   logic              c1_start;
   logic              c2_start;
   logic              c3_start;
   logic              c4_start;
   logic [DATA_W-1:0] c1_bus_in;
   logic [DATA_W-1:0] c2_bus_in;
   logic [DATA_W-1:0] c3_bus_in;
   logic [DATA_W-1:0] c4_bus_in;
   logic              c1_endp;
   logic              c2_endp;
   logic              c3_endp;
   logic              c4_endp;

   logic [2:0]        select_core;
   logic              result_valid;
   logic              result_ready;
   logic              all_idle;

   modport slave (
      input  job_valid, job_data, c1_endp, c2_endp, c3_endp, c4_endp, result_ready,
      output job_ready, c1_start, c2_start, c3_start, c4_start,
             c1_bus_in, c2_bus_in, c3_bus_in, c4_bus_in,
             select_core, result_valid, all_idle
   );

   modport master (
      output job_valid, job_data, c1_endp, c2_endp, c3_endp, c4_endp, result_ready,
      input  job_ready, c1_start, c2_start, c3_start, c4_start,
             c1_bus_in, c2_bus_in, c3_bus_in, c4_bus_in,
             select_core, result_valid, all_idle
   );
endinterface

// File: rtl/core_dispatcher.sv
// Dispatches host jobs onto four cores and presents finished cores one at a time on the output mux.
// Define DISPATCH_RR_EN for round-robin selection on both paths; default is fixed priority, core 1 first.
module core_dispatcher #(
   parameter int DATA_W    = 24,
   parameter int NUM_CORES = 4
) (
   input  logic             clk,
   input  logic             rstn,
   core_dispatcher_if.slave bus,
   output logic             dbg_state_o
);
   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t               state_q, state_d;
   logic [NUM_CORES-1:0] busy_q, busy_d;
   logic [NUM_CORES-1:0] done_q, done_d;
   logic [NUM_CORES-1:0] start_q, start_d;
   logic [NUM_CORES-1:0] endp;
   logic [DATA_W-1:0]    bus_in_q [NUM_CORES];
   logic [DATA_W-1:0]    bus_in_d [NUM_CORES];
   logic [2:0]           sel_q, sel_d;
   logic                 all_idle_q;
   logic [1:0]           disp_from, res_from;
   logic [2:0]           disp_pick, res_pick;
   logic [1:0]           pres_idx;
   logic                 accept;

   // Returns {found, index}: first set request at or after 'from', wrapping around.
   function automatic logic [2:0] pick_first(input logic [3:0] req, input logic [1:0] from);
      logic [3:0] rot;
      logic [2:0] res;
      rot = 4'({req, req} >> from);
      res = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (rot[i]) res = {1'b1, from + 2'(i)};
      end
      return res;
   endfunction

`ifdef DISPATCH_RR_EN
   logic [1:0] disp_ptr_q, disp_ptr_d;
   logic [1:0] res_ptr_q, res_ptr_d;

   assign disp_from = disp_ptr_q;
   assign res_from  = res_ptr_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         disp_ptr_q <= 2'd0;
         res_ptr_q  <= 2'd0;
      end else begin
         disp_ptr_q <= disp_ptr_d;
         res_ptr_q  <= res_ptr_d;
      end
   end
`else
   assign disp_from = 2'd0;
   assign res_from  = 2'd0;
`endif

   assign endp      = {bus.c4_endp, bus.c3_endp, bus.c2_endp, bus.c1_endp};
   assign disp_pick = pick_first(~busy_q, disp_from);
   assign res_pick  = pick_first(done_q, res_from);
   assign accept    = bus.job_valid & disp_pick[2];
   assign pres_idx  = sel_q[1:0] - 2'd1;

   always_comb begin
      busy_d   = busy_q;
      done_d   = done_q;
      start_d  = '0;
      bus_in_d = bus_in_q;
      sel_d    = sel_q;
      state_d  = state_q;
`ifdef DISPATCH_RR_EN
      disp_ptr_d = disp_ptr_q;
      res_ptr_d  = res_ptr_q;
`endif

      // start_q marks the edge after launch, when endp still reflects the previous job;
      // on the launch edge itself busy_q is still 0.
      for (int k = 0; k < NUM_CORES; k++) begin
         if (busy_q[k] && endp[k] && !start_q[k]) done_d[k] = 1'b1;
      end

      if (accept) begin
         busy_d[disp_pick[1:0]]   = 1'b1;
         start_d[disp_pick[1:0]]  = 1'b1;
         bus_in_d[disp_pick[1:0]] = bus.job_data;
`ifdef DISPATCH_RR_EN
         disp_ptr_d = disp_pick[1:0] + 2'd1;
`endif
      end

      case (state_q)
         ST_IDLE: begin
            if (res_pick[2]) begin
               sel_d   = {1'b0, res_pick[1:0]} + 3'd1;
               state_d = ST_PRESENT;
`ifdef DISPATCH_RR_EN
               res_ptr_d = res_pick[1:0] + 2'd1;
`endif
            end
         end
         ST_PRESENT: begin
            if (bus.result_ready) begin
               done_d[pres_idx] = 1'b0;
               busy_d[pres_idx] = 1'b0;
               sel_d            = 3'd0;
               state_d          = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         busy_q     <= '0;
         done_q     <= '0;
         start_q    <= '0;
         sel_q      <= 3'd0;
         all_idle_q <= 1'b1;
         for (int k = 0; k < NUM_CORES; k++) begin
            bus_in_q[k] <= '0;
         end
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         start_q    <= start_d;
         sel_q      <= sel_d;
         all_idle_q <= ~|busy_q;
         for (int k = 0; k < NUM_CORES; k++) begin
            bus_in_q[k] <= bus_in_d[k];
         end
      end
   end

   assign bus.job_ready    = ~&busy_q;
   assign bus.c1_start     = start_q[0];
   assign bus.c2_start     = start_q[1];
   assign bus.c3_start     = start_q[2];
   assign bus.c4_start     = start_q[3];
   assign bus.c1_bus_in    = bus_in_q[0];
   assign bus.c2_bus_in    = bus_in_q[1];
   assign bus.c3_bus_in    = bus_in_q[2];
   assign bus.c4_bus_in    = bus_in_q[3];
   assign bus.select_core  = sel_q;
   assign bus.result_valid = (state_q == ST_PRESENT);
   assign bus.all_idle     = all_idle_q;
   assign dbg_state_o      = (state_q == ST_PRESENT);
endmodule

// File: tb/tb_core_dispatcher.sv
// Bench for core_dispatcher: directed scenarios with literal expectations plus a randomized run,
// all checked every cycle against a job-level reference model.
module tb_core_dispatcher;
   localparam int W = 24;

`ifdef DISPATCH_RR_EN
   localparam int FILL_BASE  = 1;
   localparam int SIM_FIRST  = 3;
   localparam int SIM_SECOND = 1;
`else
   localparam int FILL_BASE  = 0;
   localparam int SIM_FIRST  = 1;
   localparam int SIM_SECOND = 3;
`endif

   // clock / reset
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   logic         job_valid_v;
   logic [W-1:0] job_data_v;
   logic         result_ready_v;
   logic [3:0]   endp_v;
   logic         dbg_state;

   core_dispatcher_if #(.DATA_W(W)) dif ();

   assign dif.job_valid    = job_valid_v;
   assign dif.job_data     = job_data_v;
   assign dif.result_ready = result_ready_v;
   assign dif.c1_endp      = endp_v[0];
   assign dif.c2_endp      = endp_v[1];
   assign dif.c3_endp      = endp_v[2];
   assign dif.c4_endp      = endp_v[3];

   core_dispatcher #(.DATA_W(W), .NUM_CORES(4)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .bus         (dif),
      .dbg_state_o (dbg_state)
   );

   wire  [3:0]   dut_start = {dif.c4_start, dif.c3_start, dif.c2_start, dif.c1_start};
   logic [W-1:0] dut_bus [4];
   assign dut_bus[0] = dif.c1_bus_in;
   assign dut_bus[1] = dif.c2_bus_in;
   assign dut_bus[2] = dif.c3_bus_in;
   assign dut_bus[3] = dif.c4_bus_in;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // reference model: job-level bookkeeping per core
   bit   [3:0]   m_busy     = '0;
   bit   [3:0]   m_done     = '0;
   bit   [3:0]   m_start    = '0;
   logic [W-1:0] m_bus [4]  = '{default: '0};
   int           m_since [4] = '{default: 2};
   int           m_present  = 0;
   bit           m_all_idle = 1'b1;
   int           m_disp_ptr = 0;
   int           m_res_ptr  = 0;
   logic [2:0]   exp_q[$];

   function automatic int pick(input bit [3:0] m, input int from);
      for (int i = 0; i < 4; i++) begin
         if (m[(from + i) % 4]) return (from + i) % 4;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge rstn) begin : model
      bit [3:0] nb, nd, ns;
      int d, r, p;
      if (!rstn) begin
         m_busy     <= '0;
         m_done     <= '0;
         m_start    <= '0;
         m_present  <= 0;
         m_all_idle <= 1'b1;
         m_disp_ptr <= 0;
         m_res_ptr  <= 0;
         for (int k = 0; k < 4; k++) begin
            m_bus[k]   <= '0;
            m_since[k] <= 2;
         end
         exp_q.delete();
      end else begin
         nb = m_busy;
         nd = m_done;
         ns = '0;
         d  = -1;
         if (job_valid_v && m_busy != 4'hf) d = pick(~m_busy, m_disp_ptr);
         // m_since = edges completed since launch; endp counts only from the second edge after it
         for (int k = 0; k < 4; k++) begin
            if (m_busy[k] && endp_v[k] && m_since[k] >= 1) nd[k] = 1'b1;
            m_since[k] <= (k == d) ? 0 : ((m_since[k] < 2) ? m_since[k] + 1 : 2);
         end
         if (d >= 0) begin
            nb[d] = 1'b1;
            ns[d] = 1'b1;
            m_bus[d] <= job_data_v;
`ifdef DISPATCH_RR_EN
            m_disp_ptr <= (d + 1) % 4;
`endif
         end
         if (m_present == 0) begin
            r = pick(m_done, m_res_ptr);
            if (r >= 0) begin
               m_present <= r + 1;
               exp_q.push_back(3'(r + 1));
`ifdef DISPATCH_RR_EN
               m_res_ptr <= (r + 1) % 4;
`endif
            end
         end else if (result_ready_v) begin
            p = m_present - 1;
            nd[p] = 1'b0;
            nb[p] = 1'b0;
            m_present <= 0;
         end
         m_all_idle <= (m_busy == 4'h0);
         m_busy     <= nb;
         m_done     <= nd;
         m_start    <= ns;
      end
   end

   // scoreboard: every output every cycle, plus result order through exp_q
   always @(negedge clk) begin
      logic [2:0] exp_sel;
      chk("job_ready", dif.job_ready, (m_busy != 4'hf));
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("c%0d_start", k + 1), dut_start[k], m_start[k]);
         chk($sformatf("c%0d_bus_in", k + 1), dut_bus[k], m_bus[k]);
      end
      chk("select_core", dif.select_core, m_present);
      chk("result_valid", dif.result_valid, (m_present != 0));
      chk("all_idle", dif.all_idle, m_all_idle);
      chk("dbg_state", dbg_state, (m_present != 0));
      if (rstn && dif.result_valid && result_ready_v) begin
         chk("result_pending", (exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            exp_sel = exp_q.pop_front();
            chk("result_core", dif.select_core, exp_sel);
         end
      end
   end

   // driver tasks
   task automatic wait_valid(input int budget, input string name);
      int n = 0;
      @(negedge clk);
      while (!dif.result_valid && n < budget) begin
         @(negedge clk);
         n++;
      end
      chk(name, dif.result_valid, 1);
   endtask

   task automatic consume();
      @(posedge clk); #1 result_ready_v = 1'b1;
      @(posedge clk); #1 result_ready_v = 1'b0;
   endtask

   logic [W-1:0] jobs [8] = '{24'h111111, 24'h222222, 24'h333333, 24'h444444,
                              24'h555555, 24'h5A5A5A, 24'hC3C3C3, 24'h123456};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, expected completion before 1ms");
      $fatal(1);
   end

   initial begin
      rstn = 1'b0;
      job_valid_v = 1'b0;
      job_data_v = '0;
      result_ready_v = 1'b0;
      endp_v = '0;

      repeat (2) @(negedge clk);
      chk("rst_select", dif.select_core, 0);
      chk("rst_valid", dif.result_valid, 0);
      chk("rst_all_idle", dif.all_idle, 1);
      chk("rst_start", dut_start, 0);
      @(posedge clk); #1 rstn = 1'b1;

      // single job on core 1
      @(posedge clk); #1 job_valid_v = 1'b1; job_data_v = 24'hABCDEF;
      @(posedge clk); #1 job_valid_v = 1'b0;
      @(negedge clk);
      chk("t1_c1_start", dif.c1_start, 1);
      chk("t1_c1_bus", dif.c1_bus_in, 24'hABCDEF);
      @(negedge clk);
      chk("t1_c1_start_width", dif.c1_start, 0);
      repeat (4) @(posedge clk);
      #1 endp_v[0] = 1'b1;
      wait_valid(12, "t1_result_timeout");
      chk("t1_select", dif.select_core, 1);
      consume();
      endp_v[0] = 1'b0;
      @(negedge clk);
      chk("t1_select_after", dif.select_core, 0);
      chk("t1_valid_after", dif.result_valid, 0);
      @(negedge clk);
      chk("t1_all_idle", dif.all_idle, 1);

      // fill all cores back to back
      @(posedge clk); #1 job_valid_v = 1'b1; job_data_v = jobs[0];
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (i < 3) job_data_v = jobs[i + 1];
         else job_valid_v = 1'b0;
         @(negedge clk);
         chk("fill_start", dut_start, 4'b0001 << ((FILL_BASE + i) % 4));
      end
      chk("fill_job_ready", dif.job_ready, 0);

      // fifth job stalls; core 2 is freed while its endp stays high across the new launch
      @(posedge clk); #1 job_valid_v = 1'b1; job_data_v = jobs[4];
      repeat (3) begin
         @(negedge clk);
         chk("stall_job_ready", dif.job_ready, 0);
      end
      @(posedge clk); #1 endp_v[1] = 1'b1;
      wait_valid(12, "t2_result_timeout");
      chk("t2_select", dif.select_core, 2);
      consume();
      @(posedge clk); #1 job_valid_v = 1'b0;
      @(negedge clk);
      chk("stale_c2_start", dif.c2_start, 1);
      chk("stale_c2_bus", dif.c2_bus_in, jobs[4]);
      chk("stale_guard_e0", dif.result_valid, 0);
      @(negedge clk);
      chk("stale_guard_e1", dif.result_valid, 0);
      @(negedge clk);
      chk("stale_guard_e2", dif.result_valid, 0);
      @(negedge clk);
      chk("stale_valid_e3", dif.result_valid, 1);
      chk("stale_select_e3", dif.select_core, 2);

      // backpressure
      repeat (10) begin
         @(negedge clk);
         chk("bp_select", dif.select_core, 2);
         chk("bp_valid", dif.result_valid, 1);
      end
      consume();
      endp_v[1] = 1'b0;

      // cores 1 and 3 finish on the same edge
      @(posedge clk); #1 endp_v[0] = 1'b1; endp_v[2] = 1'b1;
      wait_valid(12, "sim_result_timeout");
      chk("sim_first", dif.select_core, SIM_FIRST);
      consume();
      @(negedge clk);
      chk("sim_gap_select", dif.select_core, 0);
      chk("sim_gap_valid", dif.result_valid, 0);
      @(negedge clk);
      chk("sim_second", dif.select_core, SIM_SECOND);
      chk("sim_second_valid", dif.result_valid, 1);
      consume();
      endp_v = '0;

      // reset while three cores are busy and core 4 is presented
      @(posedge clk); #1 job_valid_v = 1'b1; job_data_v = jobs[5];
      @(posedge clk); #1 job_data_v = jobs[6];
      @(posedge clk); #1 job_valid_v = 1'b0; endp_v[3] = 1'b1;
      wait_valid(12, "rr_result_timeout");
      chk("mid_select", dif.select_core, 4);
      @(posedge clk); #3 rstn = 1'b0;
      #1;
      chk("mid_rst_select", dif.select_core, 0);
      chk("mid_rst_valid", dif.result_valid, 0);
      chk("mid_rst_all_idle", dif.all_idle, 1);
      chk("mid_rst_job_ready", dif.job_ready, 1);
      chk("mid_rst_start", dut_start, 0);
      for (int k = 0; k < 4; k++) chk("mid_rst_bus", dut_bus[k], 0);
      @(posedge clk); #1 rstn = 1'b1; endp_v = '0;
      job_valid_v = 1'b1; job_data_v = jobs[7];
      @(posedge clk); #1 job_valid_v = 1'b0;
      @(negedge clk);
      chk("post_rst_c1_start", dif.c1_start, 1);
      chk("post_rst_c1_bus", dif.c1_bus_in, jobs[7]);

      // randomized traffic with one reset in the middle
      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(posedge clk); #1;
         job_valid_v    = 1'($urandom_range(0, 1));
         job_data_v     = 24'($urandom);
         result_ready_v = ($urandom_range(0, 9) < 6);
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 5) == 0) endp_v[k] = ~endp_v[k];
         end
         if (cyc == 1200) rstn = 1'b0;
         if (cyc == 1203) rstn = 1'b1;
      end

      // drain
      @(posedge clk); #1 job_valid_v = 1'b0; endp_v = 4'hf; result_ready_v = 1'b1;
      repeat (60) @(posedge clk);
      @(negedge clk);
      chk("drain_all_idle", dif.all_idle, 1);
      chk("drain_job_ready", dif.job_ready, 1);
      chk("drain_queue", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
